// File: rtl/if_fetch_if.sv
// Instruction-memory bus between if_fetch and instruction memory.
// The bus carries one outstanding read at a time.
//   req    : fetch request from the fetch stage (combinational)
//   addr   : fetch address, word aligned
//   gnt    : memory accepted the request this cycle
//   rvalid : read data valid, at least one cycle after gnt
//   rdata  : instruction word
// master = fetch stage, slave = memory.
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage. Owns the PC and reads instruction memory with
// at most one request outstanding. Presents {pc, instruction} pairs to
// if_id and absorbs one response that lands while the pipeline is stalled.
//
// Ports:
//   i_Clk, i_reset    : clock, asynchronous active-high reset
//   i_jump_flag/addr  : redirect from ex, highest priority
//   i_stall           : downstream cannot accept, output holds
//   mem_bus           : instruction-memory bus (master side)
//   o_pc_addr         : PC of the presented instruction, 0 when invalid
//   o_inst_data       : instruction, NOP when invalid
//   o_inst_valid      : presented instruction is real
//
// state  | meaning
// S_REQ  | no request outstanding, issuing at pc
// S_WAIT | one request outstanding, result wanted
// S_KILL | one request outstanding, result discarded (jump happened)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_Clk,
  input  logic        i_reset,
  input  logic        i_jump_flag,
  input  logic [31:0] i_jump_addr,
  input  logic        i_stall,
  if_fetch_if.master  mem_bus,
  output logic [31:0] o_pc_addr,
  output logic [31:0] o_inst_data,
  output logic        o_inst_valid
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_data_q, out_data_d;

  logic mem_req;
  logic granted;
  logic deliver;

  // Jump targets are word aligned; the low bits are dropped.
  logic unused_jump_lsb;
  assign unused_jump_lsb = ^i_jump_addr[1:0];

  // No request while a word is parked in the buffer, so the buffer never
  // has to hold more than one response.
  assign mem_req = (state_q == S_REQ) && !buf_valid_q && !i_jump_flag;
  assign granted = mem_req && mem_bus.gnt;
  // A response in S_WAIT is only wanted if no jump arrives alongside it.
  assign deliver = (state_q == S_WAIT) && mem_bus.rvalid && !i_jump_flag;

  assign mem_bus.req  = mem_req;
  assign mem_bus.addr = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_data_d  = buf_data_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_data_d  = out_data_q;

    case (state_q)
      S_REQ:   if (granted) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_bus.rvalid)   state_d = S_REQ;
        else if (i_jump_flag) state_d = S_KILL;
      end
      S_KILL:  if (mem_bus.rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (i_jump_flag) begin
      pc_d = {i_jump_addr[31:2], 2'b00};
    end else if (granted) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end

    if (i_jump_flag) begin
      out_valid_d = 1'b0;
      out_pc_d    = 32'd0;
      out_data_d  = NOP;
      buf_valid_d = 1'b0;
    end else if (!i_stall) begin
      if (buf_valid_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = buf_pc_q;
        out_data_d  = buf_data_q;
        buf_valid_d = 1'b0;
      end else if (deliver) begin
        out_valid_d = 1'b1;
        out_pc_d    = req_pc_q;
        out_data_d  = mem_bus.rdata;
      end else begin
        out_valid_d = 1'b0;
        out_pc_d    = 32'd0;
        out_data_d  = NOP;
      end
    end else if (deliver) begin
      // Stalled: an empty output slot may still fill, otherwise park it.
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = req_pc_q;
        out_data_d  = mem_bus.rdata;
      end else begin
        buf_valid_d = 1'b1;
        buf_pc_d    = req_pc_q;
        buf_data_d  = mem_bus.rdata;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'd0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'd0;
      buf_data_q  <= NOP;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'd0;
      out_data_q  <= NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_data_q  <= buf_data_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_data_q  <= out_data_d;
    end
  end

  assign o_pc_addr    = out_pc_q;
  assign o_inst_data  = out_data_q;
  assign o_inst_valid = out_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] XKEY = 32'hA5A5_0000;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        i_Clk;
  logic        i_reset;
  logic        i_jump_flag;
  logic [31:0] i_jump_addr;
  logic        i_stall;
  logic [31:0] o_pc_addr;
  logic [31:0] o_inst_data;
  logic        o_inst_valid;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(RPC)) dut (
    .i_Clk       (i_Clk),
    .i_reset     (i_reset),
    .i_jump_flag (i_jump_flag),
    .i_jump_addr (i_jump_addr),
    .i_stall     (i_stall),
    .mem_bus     (bus),
    .o_pc_addr   (o_pc_addr),
    .o_inst_data (o_inst_data),
    .o_inst_valid(o_inst_valid)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_assert = 0;
  int n_fail   = 0;

  // memory model / policy
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          m_pending;
  bit          m_wanted;
  bit          m_granted_now;
  logic [31:0] m_addr;
  int          m_cnt;
  // behavioural view of the fetch stage
  bit          m_out_v;
  logic [31:0] m_out_pc;
  bit          m_buf_v;
  logic [31:0] m_buf_pc;
  logic [31:0] exp_fetch;
  logic [31:0] exp_next_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pending   = 0;
    m_wanted    = 0;
    m_out_v     = 0;
    m_out_pc    = 32'd0;
    m_buf_v     = 0;
    exp_fetch   = RPC;
    exp_next_pc = RPC;
  endtask

  task automatic do_reset(input int hold);
    i_reset     = 1'b1;
    i_jump_flag = 1'b0;
    i_stall     = 1'b0;
    bus.gnt     = 1'b0;
    bus.rvalid  = 1'b0;
    #1;
    chk("rst_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("rst_pc", o_pc_addr, 32'd0);
    chk("rst_data", o_inst_data, NOP);
    model_reset();
    repeat (hold) @(posedge i_Clk);
    #1;
    i_reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, play memory, predict, clock, check.
  task automatic step(input bit jump, input logic [31:0] jaddr, input bit stall);
    bit          rv, g, deliver, exp_req, prev_valid;
    logic [31:0] dpc;
    i_jump_flag = jump;
    i_jump_addr = jaddr;
    i_stall     = stall;
    rv = m_pending && (m_cnt == 1);
    if (m_pending && !rv) m_cnt--;
    bus.rvalid = rv;
    bus.rdata  = rv ? (m_addr ^ XKEY) : $urandom;
    bus.gnt    = 1'b0;
    #1;
    exp_req = !m_pending && !jump && !m_buf_v;
    chk("mem_req", {31'd0, bus.req}, {31'd0, exp_req});
    g = 0;
    if (bus.req) begin
      chk("mem_addr", bus.addr, exp_fetch);
      g = ($urandom_range(99) < gnt_pct);
    end
    bus.gnt = g;
    deliver = rv && m_wanted && !jump;
    dpc     = m_addr;

    if (jump) begin
      m_out_v = 0;
      m_buf_v = 0;
    end else if (!stall) begin
      if (m_buf_v) begin
        m_out_v = 1; m_out_pc = m_buf_pc; m_buf_v = 0;
      end else if (deliver) begin
        m_out_v = 1; m_out_pc = dpc;
      end else begin
        m_out_v = 0;
      end
    end else if (deliver) begin
      if (!m_out_v) begin
        m_out_v = 1; m_out_pc = dpc;
      end else begin
        m_buf_v = 1; m_buf_pc = dpc;
      end
    end

    if (rv) m_pending = 0;
    if (jump && m_pending) m_wanted = 0;
    m_granted_now = g;
    if (g) begin
      m_pending = 1;
      m_wanted  = 1;
      m_addr    = bus.addr;
      m_cnt     = $urandom_range(lat_max, lat_min);
      exp_fetch = bus.addr + 32'd4;
    end
    if (jump) begin
      exp_fetch   = {jaddr[31:2], 2'b00};
      exp_next_pc = {jaddr[31:2], 2'b00};
    end
    prev_valid = o_inst_valid;

    @(posedge i_Clk);
    #1;
    chk("out_valid", {31'd0, o_inst_valid}, {31'd0, m_out_v});
    chk("out_pc", o_pc_addr, m_out_v ? m_out_pc : 32'd0);
    chk("out_data", o_inst_data, m_out_v ? (m_out_pc ^ XKEY) : NOP);
    // program order: each newly presented instruction follows the last one
    if (o_inst_valid && !jump && (!stall || !prev_valid)) begin
      chk("stream_pc", o_pc_addr, exp_next_pc);
      exp_next_pc = exp_next_pc + 32'd4;
    end
  endtask

  task automatic wait_grant(input string tag);
    m_granted_now = 0;
    for (int i = 0; i < 12 && !m_granted_now; i++) step(0, 32'd0, 0);
    chk(tag, {31'd0, m_granted_now}, 32'd1);
  endtask

  initial begin
    bit          found;
    bit          j, s;
    logic [31:0] ja;

    i_jump_addr = 32'd0;
    bus.rdata   = 32'd0;

    // 1: back-to-back fetch, gnt immediate, rvalid one cycle later
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset(2);
    for (int i = 0; i < 8; i++) step(0, 32'd0, 0);
    chk("t1_valid", {31'd0, o_inst_valid}, 32'd1);
    chk("t1_pc", o_pc_addr, 32'h0000_000C);
    chk("t1_data", o_inst_data, 32'h0000_000C ^ XKEY);

    // 2: jump while waiting, stale rvalid two cycles later
    lat_min = 3; lat_max = 3;
    wait_grant("t2_grant");
    step(1, 32'h0000_0103, 0);
    chk("t2_bubble", {31'd0, o_inst_valid}, 32'd0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(0, 32'd0, 0);
      found = o_inst_valid;
    end
    chk("t2_found", {31'd0, found}, 32'd1);
    chk("t2_first_pc", o_pc_addr, 32'h0000_0100);

    // 3: jump in the same cycle as rvalid, no kill cycle
    lat_min = 2; lat_max = 2;
    wait_grant("t3_grant");
    step(0, 32'd0, 0);
    step(1, 32'h0000_0200, 0);
    i_jump_flag = 1'b0;
    #1;
    chk("t3_req_next", {31'd0, bus.req}, 32'd1);
    chk("t3_addr_next", bus.addr, 32'h0000_0200);

    // 4: stall with a response arriving mid-stall
    lat_min = 1; lat_max = 1;
    step(1, 32'h0000_0008, 0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(0, 32'd0, 0);
      found = o_inst_valid && (o_pc_addr == 32'h0000_0008);
    end
    chk("t4_found", {31'd0, found}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'd0, 1);
      chk("t4_hold_pc", o_pc_addr, 32'h0000_0008);
    end
    step(0, 32'd0, 0);
    chk("t4_release_pc", o_pc_addr, 32'h0000_000C);
    chk("t4_release_data", o_inst_data, 32'h0000_000C ^ XKEY);
    #1;
    chk("t4_next_req", {31'd0, bus.req}, 32'd1);
    chk("t4_next_addr", bus.addr, 32'h0000_0010);

    // 5: reset while waiting
    lat_min = 3; lat_max = 3;
    wait_grant("t5_grant");
    step(0, 32'd0, 0);
    do_reset(1);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) step(0, 32'd0, 0);

    // 6: PC wrap
    step(1, 32'hFFFF_FFFC, 0);
    step(0, 32'd0, 0);
    step(0, 32'd0, 0);
    #1;
    chk("t6_wrap_req", {31'd0, bus.req}, 32'd1);
    chk("t6_wrap_addr", bus.addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(0, 32'd0, 0);

    // random traffic: grant delays, latencies, stalls, jumps, resets
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      j  = ($urandom_range(99) < 4);
      s  = ($urandom_range(99) < 30);
      ja = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(j, ja, s);
      if (i == 1000 || i == 2000) do_reset(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage of the RISC-V core, directly upstream of `if_id`. It owns the PC and issues one-outstanding-request reads to instruction memory over a req/gnt/rvalid bus. It redirects on jumps from ex and presents `{pc, instruction}` pairs that feed `if_id` inputs `i_pc_addr`/`i_inst_data`. A one-entry pending buffer absorbs a response that arrives while the pipeline is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `i_Clk`  in  1  clock.
- `i_reset`  in  1  reset; asynchronous, active-high.
- `i_jump_flag`  in  1  redirect pulse from ex; highest priority.
- `i_jump_addr`  in  32  redirect target; bits [1:0] forced to 0.
- `i_stall`  in  1  downstream cannot accept; output holds.
- `o_mem_req`  out  1  fetch request; combinational.
- `o_mem_addr`  out  32  fetch address (= PC); combinational.
- `i_mem_gnt`  in  1  request accepted this cycle.
- `i_mem_rvalid`  in  1  read data valid; at least 1 cycle after gnt.
- `i_mem_rdata`  in  32  instruction word.
- `o_pc_addr`  out  32  PC of the presented instruction; 0 when invalid.
- `o_inst_data`  out  32  instruction; NOP (32'h0000_0013) when invalid.
- `o_inst_valid`  out  1  presented instruction is real.

## Operation
- FSM states:
  - S_REQ: issuing.
  - S_WAIT: one request outstanding, result wanted.
  - S_KILL: one request outstanding, result to be discarded.
- Request rule: `o_mem_req` = (state==S_REQ) && !buf_valid && !i_jump_flag. `o_mem_addr` = pc.
- S_REQ transitions:
  - on req && gnt: req_pc <= pc, pc <= pc+4 (32-bit wrap, 0xFFFF_FFFC+4 = 0), go to S_WAIT.
  - otherwise stay.
- S_WAIT transitions:
  - on rvalid: the word {req_pc, rdata} is delivered, then go to S_REQ.
  - on i_jump_flag without rvalid: go to S_KILL.
  - on i_jump_flag with rvalid in the same cycle: discard the word, go to S_REQ.
- S_KILL transitions: on rvalid, discard the word and go to S_REQ. A jump in S_KILL stays in S_KILL.
- Delivery:
  - if i_stall=0, or the output is invalid: load the output registers, valid=1.
  - otherwise: load the pending buffer, buf_valid=1.
- Output registers, each cycle with i_stall=0:
  - if buf_valid: load from the buffer and clear buf_valid;
  - else if a delivery is occurring: load it;
  - else: load NOP / pc 0 / valid 0.
- Output registers with i_stall=1: hold. Exception: an invalid output may take a delivery.
- Jump, in any state (i_jump_flag=1):
  - pc <= {i_jump_addr[31:2], 2'b00};
  - output <= NOP / 0 / valid 0, regardless of i_stall;
  - buf_valid <= 0;
  - no request that cycle.
- Reset values:
  - state S_REQ, pc = RESET_PC, req_pc = 0;
  - buf_valid 0, o_inst_valid 0;
  - o_inst_data NOP, o_pc_addr 0.
- Reset mid-operation: any outstanding request is forgotten. The memory bus must be reset together with this block.

## Timing
- First `o_mem_req` is in the first clock after reset deasserts, with address RESET_PC.
- With gnt at T and rvalid at T+k (k≥1):
  - output valid from edge T+k+1;
  - next req at T+k+1.
- Peak throughput: one instruction per 2 cycles (gnt immediate, k=1).
- Jump at cycle J:
  - bubble on the output from J+1;
  - first request to the target at J+1 if no request is outstanding;
  - otherwise at the cycle after the stale rvalid.
- Stall: the output is stable for every cycle i_stall=1 (except invalid→valid fill). At most one response is buffered. While buf_valid, no requests are made.
- Between gnt and rvalid, `o_mem_req`=0. There is never more than one outstanding request.

## Test plan
- Reset, RESET_PC=0, memory with gnt=1 and rvalid one cycle later, returning addr^32'hA5A5_0000 -> requests at 0, 4, 8 on every other cycle; o_pc_addr/o_inst_data match each address, valid one cycle after rvalid.
- Jump to 32'h0000_0103 while in S_WAIT, rvalid two cycles later -> stale word never appears; output NOP/0/invalid; next request address 0x100; first valid output has pc 0x100.
- Jump in the same cycle as rvalid -> word discarded; request to target on the next cycle; no S_KILL cycle.
- Hold i_stall=1 for 4 cycles with a valid output (pc 0x8) and a response for 0xC arriving mid-stall -> output stays 0x8; no further requests; after release, 0xC appears next cycle, then 0x10 is fetched.
- Assert reset mid-S_WAIT for 1 cycle -> all outputs return to reset values immediately; first post-reset request is at RESET_PC.
- PC at 0xFFFF_FFFC, granted -> next request address 0x0000_0000.
